// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queued, handshaked command/response sequencer for a combinational ALU
// Commands are buffered in a small FIFO, held on the ALU for SETTLE cycles, and the result is returned registered.
module alu_cmd_sequencer #(
  parameter int W      = 4,
  parameter int OPW    = 4,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_op,
  input  logic [W-1:0]   cmd_a,
  input  logic [W-1:0]   cmd_b,
  input  logic           cmd_cin,
  output logic [OPW-1:0] alu_opcode,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_cin,
  input  logic [W-1:0]   alu_y,
  input  logic           alu_cout,
  input  logic           alu_v,
  input  logic           alu_n,
  input  logic           alu_z,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [OPW-1:0] rsp_op,
  output logic [W-1:0]   rsp_y,
  output logic [3:0]     rsp_flags,
  output logic           busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = OPW + 2 * W + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t          state, next_state;
  logic [PW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ready_en;
  logic            empty, full, push, pop, cnt_dec, capture, rsp_clr;
  logic [PW-1:0]   head;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // ready_en keeps cmd_ready low through reset without a combinational path from rst_n
  assign cmd_ready = ready_en && !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    cnt_dec    = 1'b0;
    capture    = 1'b0;
    rsp_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt != '0) begin
          cnt_dec = 1'b1;
        end else begin
          capture    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_clr = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            next_state = DRIVE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b, cmd_cin};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      ready_en   <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_op     <= '0;
      rsp_y      <= '0;
      rsp_flags  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr                                <= rd_ptr + 1'b1;
        {alu_opcode, alu_a, alu_b, alu_cin}   <= head;
        cnt                                   <= CNT_LOAD;
      end else if (cnt_dec) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_op    <= alu_opcode;
        rsp_y     <= alu_y;
        rsp_flags <= {alu_cout, alu_v, alu_n, alu_z};
      end else if (rsp_clr) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
// Drives a SETTLE=1 instance with a combinational ALU model and a SETTLE=3 instance with a slow ALU model.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_cin;
  logic [3:0] cmd_op, cmd_a, cmd_b;
  logic [3:0] alu_opcode, alu_a, alu_b;
  logic       alu_cin, alu_cout, alu_v, alu_n, alu_z;
  logic [3:0] alu_y;
  logic       rsp_valid, rsp_ready, busy;
  logic [3:0] rsp_op, rsp_y, rsp_flags;

  logic       cmd_valid3, cmd_ready3, cmd_cin3;
  logic [3:0] cmd_op3, cmd_a3, cmd_b3;
  logic [3:0] alu_opcode3, alu_a3, alu_b3;
  logic       alu_cin3, alu_cout3, alu_v3, alu_n3, alu_z3;
  logic [3:0] alu_y3;
  logic       rsp_valid3, rsp_ready3, busy3;
  logic [3:0] rsp_op3, rsp_y3, rsp_flags3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [11:0] rx_q[$];
  int          rx_t[$];

  // Returns {y, cout, v, n, z}
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
    logic [4:0] s;
    logic [3:0] y;
    logic       c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        y = s[3:0]; c = s[4];
        v = (a[3] == b[3]) && (y[3] != a[3]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        y = s[3:0]; c = s[4];
        v = (a[3] != b[3]) && (y[3] != a[3]);
      end
      4'd4:    y = a & b;
      4'd5:    y = a | b;
      4'd6:    y = a ^ b;
      default: y = a;
    endcase
    return {y, c, v, y[3], (y == 4'd0)};
  endfunction

  assign {alu_y, alu_cout, alu_v, alu_n, alu_z} = alu_model(alu_opcode, alu_a, alu_b, alu_cin);

  // Slow ALU: result reflects new inputs only two cycles after they change
  logic [7:0] d1, d2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= alu_model(alu_opcode3, alu_a3, alu_b3, alu_cin3);
      d2 <= d1;
    end
  end
  assign {alu_y3, alu_cout3, alu_v3, alu_n3, alu_z3} = d2;

  alu_cmd_sequencer #(.W(4), .OPW(4), .DEPTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a),
    .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  alu_cmd_sequencer #(.W(4), .OPW(4), .DEPTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3), .cmd_a(cmd_a3),
    .cmd_b(cmd_b3), .cmd_cin(cmd_cin3),
    .alu_opcode(alu_opcode3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_cin(alu_cin3),
    .alu_y(alu_y3), .alu_cout(alu_cout3), .alu_v(alu_v3), .alu_n(alu_n3), .alu_z(alu_z3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_op(rsp_op3), .rsp_y(rsp_y3),
    .rsp_flags(rsp_flags3), .busy(busy3)
  );

  task automatic tick;
    if (rsp_valid && rsp_ready) begin
      rx_q.push_back({rsp_op, rsp_y, rsp_flags});
      rx_t.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic cin);
    int n;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int want);
    int n;
    n = 0;
    while (rx_q.size() < want && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (rx_q.size() != want) begin
      errors++;
      $display("FAIL drain_count: got %0d responses required %0d", rx_q.size(), want);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b rsp_valid=%b required 0 0 0", cmd_ready, busy, rsp_valid);
    end
    checks++;
    if ({alu_opcode, alu_a, alu_b, alu_cin, rsp_op, rsp_y, rsp_flags} !== 25'h0) begin
      errors++;
      $display("FAIL reset_data: alu=%h rsp=%h required 0", {alu_opcode, alu_a, alu_b, alu_cin},
               {rsp_op, rsp_y, rsp_flags});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || cmd_ready3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: %b/%b required 1/1", cmd_ready, cmd_ready3);
    end
  endtask

  task automatic test_single;
    rsp_ready = 1'b1;
    push_cmd(4'b0100, 4'b1100, 4'b1010, 1'b0);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: busy=%b rsp_valid=%b required 1 0", busy, rsp_valid);
    end
    tick();
    checks++;
    if (alu_a !== 4'b1100 || alu_b !== 4'b1010 || alu_opcode !== 4'b0100 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drive: op=%b a=%b b=%b rv=%b required 0100 1100 1010 0",
               alu_opcode, alu_a, alu_b, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== 4'b1000 || rsp_op !== 4'b0100 || rsp_flags !== 4'b0010) begin
      errors++;
      $display("FAIL single_rsp: rv=%b y=%b op=%b fl=%b required 1 1000 0100 0010",
               rsp_valid, rsp_y, rsp_op, rsp_flags);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: rv=%b busy=%b required 0 0", rsp_valid, busy);
    end
    rx_q.delete(); rx_t.delete();
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    push_cmd(4'd0, 4'b0111, 4'b0001, 1'b0);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({rsp_valid, rsp_op, rsp_y, rsp_flags, alu_a, alu_b} !== {1'b1, 4'h0, 4'h8, 4'h6, 4'h7, 4'h1}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rv=%b op=%h y=%h fl=%h a=%h b=%h required 1 0 8 6 7 1",
                 k, rsp_valid, rsp_op, rsp_y, rsp_flags, alu_a, alu_b);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rsp_valid=%b required 0", rsp_valid);
    end
    rsp_ready = 1'b0;
    rx_q.delete(); rx_t.delete();
  endtask

  task automatic test_full_fifo;
    logic [11:0] exp_q[$];
    logic [7:0]  r;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r = alu_model(4'd0, 4'(i), 4'd3, i[0]);
      exp_q.push_back({4'd0, r});
    end
    for (int i = 0; i < 5; i++) begin
      cmd_op = 4'd0; cmd_a = 4'(i); cmd_b = 4'd3; cmd_cin = i[0]; cmd_valid = 1'b1;
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_fill[%0d]: cmd_ready=%b required 1", i, cmd_ready);
      end
      tick();
    end
    cmd_op = 4'd0; cmd_a = 4'd5; cmd_b = 4'd3; cmd_cin = 1'b1; cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_stall: cmd_ready=%b required 0", cmd_ready);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_stall2: cmd_ready=%b rsp_valid=%b required 0 1", cmd_ready, rsp_valid);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_unstall: cmd_ready=%b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain(6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_order[%0d]: got %h required %h", i, rx_q[i], exp_q[i]);
      end
    end
    rx_q.delete(); rx_t.delete();
  endtask

  task automatic test_streaming;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_cmd(4'b0110, 4'(i), 4'b1111, 1'b0);
    drain(8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== {4'b0110, 4'(i) ^ 4'b1111, 4'b0010}) begin
        errors++;
        $display("FAIL stream_data[%0d]: got %h required %h", i, rx_q[i], {4'b0110, 4'(i) ^ 4'b1111, 4'b0010});
      end
      if (i > 0) begin
        checks++;
        if (rx_t[i] - rx_t[i-1] != 2) begin
          errors++;
          $display("FAIL stream_gap[%0d]: got %0d cycles required 2", i, rx_t[i] - rx_t[i-1]);
        end
      end
    end
    rx_q.delete(); rx_t.delete();
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) push_cmd(4'd0, 4'(i), 4'(i), 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    rx_q.delete(); rx_t.delete();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({cmd_ready, busy, rsp_valid, alu_opcode, alu_a, alu_b, alu_cin, rsp_op, rsp_y, rsp_flags} !== 28'h0) begin
      errors++;
      $display("FAIL midreset_outputs: ready=%b busy=%b rv=%b alu=%h rsp=%h required all 0",
               cmd_ready, busy, rsp_valid, {alu_opcode, alu_a, alu_b, alu_cin}, {rsp_op, rsp_y, rsp_flags});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (rx_q.size() != 0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_rsp: responses=%0d rv=%b required 0 0", rx_q.size(), rsp_valid);
    end
    push_cmd(4'd5, 4'd3, 4'd4, 1'b0);
    tick();
    checks++;
    if (alu_a !== 4'd3 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_drive: a=%h rv=%b required 3 0", alu_a, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== 4'd7 || rsp_flags !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_rsp: rv=%b y=%h fl=%b required 1 7 0000", rsp_valid, rsp_y, rsp_flags);
    end
    tick();
    rx_q.delete(); rx_t.delete();
  endtask

  task automatic test_settle3;
    rsp_ready3 = 1'b0;
    cmd_op3 = 4'b0110; cmd_a3 = 4'b1010; cmd_b3 = 4'b0101; cmd_cin3 = 1'b0; cmd_valid3 = 1'b1;
    checks++;
    if (cmd_ready3 !== 1'b1) begin
      errors++;
      $display("FAIL s3_ready: cmd_ready3=%b required 1", cmd_ready3);
    end
    tick();
    cmd_valid3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (rsp_valid3 !== 1'b0) begin
        errors++;
        $display("FAIL s3_early[%0d]: rsp_valid3=%b required 0", k, rsp_valid3);
      end
    end
    tick();
    checks++;
    if (rsp_valid3 !== 1'b1 || rsp_y3 !== 4'b1111 || rsp_flags3 !== 4'b0010 || rsp_op3 !== 4'b0110) begin
      errors++;
      $display("FAIL s3_rsp: rv=%b y=%b fl=%b op=%b required 1 1111 0010 0110",
               rsp_valid3, rsp_y3, rsp_flags3, rsp_op3);
    end
    rsp_ready3 = 1'b1;
    tick();
    checks++;
    if (rsp_valid3 !== 1'b0 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL s3_done: rv=%b busy=%b required 0 0", rsp_valid3, busy3);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; rsp_ready = 1'b0;
    cmd_valid3 = 1'b0; cmd_op3 = '0; cmd_a3 = '0; cmd_b3 = '0; cmd_cin3 = 1'b0; rsp_ready3 = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_full_fifo();
    test_streaming();
    test_reset_mid();
    test_settle3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
